// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and axis-state encoding, imported by the timing
// generator and by the display and game-datapath blocks.
`timescale 1ns/1ps
package vga_timing_gen_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    ST_VISIBLE = 2'd0,
    ST_FRONT   = 2'd1,
    ST_SYNC    = 2'd2,
    ST_BACK    = 2'd3
  } axis_state_t;

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: wrap-around counter plus VISIBLE/FRONT/SYNC/BACK state
// machine kept in step with the count. Instantiated for both axes.
`timescale 1ns/1ps
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int VISIBLE = H_VISIBLE_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_in_sync
);

  localparam logic [CNT_W-1:0] END_VIS   = CNT_W'(VISIBLE - 1);
  localparam logic [CNT_W-1:0] END_FRONT = CNT_W'(VISIBLE + FRONT - 1);
  localparam logic [CNT_W-1:0] END_SYNC  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] END_TOTAL = CNT_W'(VISIBLE + FRONT + SYNC + BACK - 1);

  logic [CNT_W-1:0] r_count;
  axis_state_t      r_state;
  axis_state_t      w_state_nxt;
  logic             w_wrap;

  assign w_wrap = i_adv && (r_count == END_TOTAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_adv) begin
      r_count <= w_wrap ? '0 : r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_VISIBLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Each state ends on its last count, so the state always matches the counter.
  always_comb begin
    w_state_nxt = r_state;
    if (i_adv) begin
      case (r_state)
        ST_VISIBLE: if (r_count == END_VIS)   w_state_nxt = ST_FRONT;
        ST_FRONT:   if (r_count == END_FRONT) w_state_nxt = ST_SYNC;
        ST_SYNC:    if (r_count == END_SYNC)  w_state_nxt = ST_BACK;
        ST_BACK:    if (r_count == END_TOTAL) w_state_nxt = ST_VISIBLE;
        default:                              w_state_nxt = ST_VISIBLE;
      endcase
    end
  end

  always_comb begin
    o_in_sync = (r_state == ST_SYNC);
    o_wrap    = w_wrap;
    o_count   = r_count;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: column/row counters, one-cycle-delayed syncs aligned with
// blanked, registered RGB, and a frame tick on entry to vertical blanking.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             r_in,
  input  logic             g_in,
  input  logic             b_in,
  output logic [CNT_W-1:0] column,
  output logic [CNT_W-1:0] row,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             r,
  output logic             g,
  output logic             b,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] H_VIS_LIM   = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_LIM   = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST_VIS  = CNT_W'(V_VISIBLE - 1);

  logic [CNT_W-1:0] w_column;
  logic [CNT_W-1:0] w_row;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_video_on;
  logic             w_unused_v_wrap;

  logic r_hsync;
  logic r_vsync;
  logic r_r;
  logic r_g;
  logic r_b;
  logic r_tick;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_adv     (ena),
    .o_count   (w_column),
    .o_wrap    (w_h_wrap),
    .o_in_sync (w_h_sync)
  );

  // Row advances only on the enabled edge that wraps the column.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_adv     (w_h_wrap),
    .o_count   (w_row),
    .o_wrap    (w_v_wrap),
    .o_in_sync (w_v_sync)
  );

  assign w_unused_v_wrap = w_v_wrap;
  assign w_video_on      = (w_column < H_VIS_LIM) && (w_row < V_VIS_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_r     <= 1'b0;
      r_g     <= 1'b0;
      r_b     <= 1'b0;
      r_tick  <= 1'b0;
    end else if (ena) begin
      r_hsync <= ~w_h_sync;
      r_vsync <= ~w_v_sync;
      r_r     <= r_in & w_video_on;
      r_g     <= g_in & w_video_on;
      r_b     <= b_in & w_video_on;
      r_tick  <= w_h_wrap && (w_row == V_LAST_VIS);
    end
  end

  // The tick is held across disabled cycles and shown only while enabled,
  // so it spans exactly one enabled cycle whatever the ena pattern.
  assign column     = w_column;
  assign row        = w_row;
  assign video_on   = w_video_on;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;
  assign frame_tick = r_tick & ena;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (17 x 13) so whole
// frames, the frame boundary and half-rate enable fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HV = 10, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 6,  VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic       r_in = 1'b0, g_in = 1'b0, b_in = 1'b0;
  logic [9:0] column, row;
  logic       video_on, hsync, vsync, r, g, b, frame_tick;

  int checks = 0;
  int errors = 0;
  int ec, er;
  logic e_hs, e_vs, e_r, e_g, e_b, e_tk;
  int hs_low, vs_low, r_high, g_high, ticks, hs_pulses;
  logic prev_hs;

  vga_timing_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
  ) dut (
    .clk (clk), .rst_n (rst_n), .ena (ena),
    .r_in (r_in), .g_in (g_in), .b_in (b_in),
    .column (column), .row (row), .video_on (video_on),
    .hsync (hsync), .vsync (vsync), .r (r), .g (g), .b (b),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (col=%0d row=%0d)", tag, act, exp, ec, er);
    end
  endtask

  task automatic model_reset();
    ec = 0; er = 0;
    e_hs = 1'b1; e_vs = 1'b1;
    e_r = 1'b0; e_g = 1'b0; e_b = 1'b0; e_tk = 1'b0;
  endtask

  task automatic clear_tallies();
    hs_low = 0; vs_low = 0; r_high = 0; g_high = 0; ticks = 0; hs_pulses = 0;
    prev_hs = hsync;
  endtask

  task automatic cycle(input logic en, input logic ri, input logic gi, input logic bi);
    int  pc, pr;
    logic vid;
    @(negedge clk);
    ena = en; r_in = ri; g_in = gi; b_in = bi;
    pc = ec; pr = er;
    if (en) begin
      vid  = (ec < HV) && (er < VV);
      e_hs = !((ec >= HV + HF) && (ec < HV + HF + HS));
      e_vs = !((er >= VV + VF) && (er < VV + VF + VS));
      e_r  = ri & vid;
      e_g  = gi & vid;
      e_b  = bi & vid;
      e_tk = (ec == HT - 1) && (er == VV - 1);
      if (ec == HT - 1) begin
        ec = 0;
        er = (er == VT - 1) ? 0 : er + 1;
      end else begin
        ec = ec + 1;
      end
    end
    @(posedge clk);
    #1;
    check("column",   column,   ec);
    check("row",      row,      er);
    check("video_on", video_on, ((ec < HV) && (er < VV)) ? 1 : 0);
    check("hsync",    hsync,    e_hs);
    check("vsync",    vsync,    e_vs);
    check("r",        r,        e_r);
    check("g",        g,        e_g);
    check("b",        b,        e_b);
    check("frame_tick", frame_tick, (e_tk && en) ? 1 : 0);
    if (en && pc == HT - 1 && pr == VT - 1) check("wrap_to_00", row * 1024 + column, 0);
    if (en && pc == HT - 1 && pr == VV - 1) check("enter_vblank", row * 1024 + column, VV * 1024);
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (r) r_high++;
    if (g) g_high++;
    if (frame_tick) ticks++;
    if (prev_hs && !hsync) hs_pulses++;
    prev_hs = hsync;
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_column", column, 0);
    check("rst_row",    row,    0);
    check("rst_hsync",  hsync,  1);
    check("rst_vsync",  vsync,  1);
    check("rst_rgb",    {r, g, b}, 0);
    check("rst_tick",   frame_tick, 0);

    @(negedge clk);
    rst_n = 1'b1;

    // One full frame at full rate; g follows column parity.
    clear_tallies();
    for (int i = 0; i < HT * VT; i++) cycle(1'b1, 1'b1, ec[0], er[0]);
    check("frame_hs_low",    hs_low,    VT * HS);
    check("frame_hs_pulses", hs_pulses, VT);
    check("frame_vs_low",    vs_low,    VS * HT);
    check("frame_r_high",    r_high,    VV * HV);
    check("frame_g_high",    g_high,    VV * HV / 2);
    check("frame_ticks",     ticks,     1);

    // Two frames with ena toggling every clock.
    clear_tallies();
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("half_hs_low", hs_low, 2 * 2 * VT * HS);
    check("half_vs_low", vs_low, 2 * 2 * VS * HT);
    check("half_r_high", r_high, 2 * 2 * VV * HV);
    check("half_ticks",  ticks,  2);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < HT * VT && !(ec == 5 && er == 3); i++) cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("reach_mid", row * 1024 + column, 3 * 1024 + 5);
    #2;
    ena = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_column", column, 0);
    check("async_row",    row,    0);
    check("async_hsync",  hsync,  1);
    check("async_vsync",  vsync,  1);
    check("async_rgb",    {r, g, b}, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_rst_col", column, 1);
    check("post_rst_row", row,    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
